// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP writeback path: fflags bit positions,
// the canonical quiet NaN and the buffered writeback entry.
package fpu_pkg;

  localparam int FLG_NX = 0;
  localparam int FLG_UF = 1;
  localparam int FLG_OF = 2;
  localparam int FLG_DZ = 3;
  localparam int FLG_NV = 4;

  localparam int ENTRY_AW = 5;
  localparam int ENTRY_DW = 32;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [ENTRY_AW-1:0] rd;
    logic [ENTRY_DW-1:0] result;
    logic [4:0]          flags;
  } fp_wb_entry_t;

endpackage

// File: rtl/fp_wb_fifo.sv
// DEPTH-entry FIFO of writeback entries; flush empties it and discards any
// push or pop presented in the same cycle.
module fp_wb_fifo
  import fpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fp_wb_entry_t entry_in,
  input  logic         pop,
  input  logic         flush,
  output fp_wb_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fp_wb_entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem[wr_ptr] <= entry_in;
  end

endmodule

// File: rtl/fp_wb_stage.sv
// FP32 writeback stage: buffers adder results, arbitrates for the FP RF write
// port and accumulates sticky fflags. Define FP_WB_CANON_NAN_EN to canonicalise NaNs.
module fp_wb_stage
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_rd,
  input  logic [DW-1:0]            in_result,
  input  logic                     in_nan,
  input  logic                     in_overflow,
  input  logic                     in_underflow,
  input  logic                     in_zero,
  input  logic                     flush,
  output logic                     rf_we,
  input  logic                     rf_gnt,
  output logic [AW-1:0]            rf_waddr,
  output logic [DW-1:0]            rf_wdata,
  input  logic                     csr_we,
  input  logic [4:0]               csr_wdata,
  output logic [4:0]               fflags,
  output logic [$clog2(DEPTH):0]   count
);

  fp_wb_entry_t entry_in;
  fp_wb_entry_t head;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic [4:0]   retire_flags;
  logic         unused_zero;

  // in_zero is only carried for debug visibility upstream; it never touches fflags.
  assign unused_zero = in_zero;

  assign in_ready = rst_n & ~full;
  assign push     = in_valid & in_ready;
  assign rf_we    = ~empty;
  assign pop      = rf_we & rf_gnt;

  always_comb begin
    entry_in               = '0;
    entry_in.rd            = in_rd;
    entry_in.result        = in_result;
    entry_in.flags[FLG_NV] = in_nan;
    entry_in.flags[FLG_DZ] = 1'b0;
    entry_in.flags[FLG_OF] = in_overflow;
    entry_in.flags[FLG_UF] = in_underflow;
    entry_in.flags[FLG_NX] = in_overflow | in_underflow;
  end

  fp_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .entry_in (entry_in),
    .pop      (pop),
    .flush    (flush),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  assign rf_waddr = head.rd;

`ifdef FP_WB_CANON_NAN_EN
  always_comb begin
    rf_wdata = head.result;
    if (head.result[30:23] == 8'hFF && head.result[22:0] != '0) rf_wdata = CANON_NAN;
  end
`else
  assign rf_wdata = head.result;
`endif

  // A flushed retire is dropped, so its flags must not leak into fflags.
  assign retire_flags = (pop && !flush) ? head.flags : 5'b0;

  always_ff @(posedge clk) begin
    if (!rst_n)      fflags <= 5'b0;
    else if (csr_we) fflags <= csr_wdata | retire_flags;
    else             fflags <= fflags | retire_flags;
  end

endmodule

// File: tb/tb_fp_wb_stage.sv
// Directed table-driven bench for fp_wb_stage, plus a mid-operation reset sequence.
module tb_fp_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic        in_nan, in_overflow, in_underflow, in_zero;
  logic        flush;
  logic        rf_we;
  logic        rf_gnt;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        csr_we;
  logic [4:0]  csr_wdata;
  logic [4:0]  fflags;
  logic [1:0]  count;

  int checks   = 0;
  int failures = 0;

`ifdef FP_WB_CANON_NAN_EN
  localparam logic [31:0] NAN_EXP = 32'h7FC0_0000;
`else
  localparam logic [31:0] NAN_EXP = 32'hFFC0_0001;
`endif

  fp_wb_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_rd        (in_rd),
    .in_result    (in_result),
    .in_nan       (in_nan),
    .in_overflow  (in_overflow),
    .in_underflow (in_underflow),
    .in_zero      (in_zero),
    .flush        (flush),
    .rf_we        (rf_we),
    .rf_gnt       (rf_gnt),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .csr_we       (csr_we),
    .csr_wdata    (csr_wdata),
    .fflags       (fflags),
    .count        (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        nan, ovf, unf, gnt, cwe;
    logic [4:0]  cwd;
    logic        fl;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [4:0]  e_ff;
    logic [1:0]  e_cnt;
    logic        e_rdy;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(logic v, logic [4:0] rd, logic [31:0] res,
                              logic nan, logic ovf, logic unf, logic gnt,
                              logic cwe, logic [4:0] cwd, logic fl,
                              logic e_we, logic [4:0] e_addr, logic [31:0] e_data,
                              logic [4:0] e_ff, logic [1:0] e_cnt, logic e_rdy);
    vec_t t;
    t.v = v; t.rd = rd; t.res = res; t.nan = nan; t.ovf = ovf; t.unf = unf;
    t.gnt = gnt; t.cwe = cwe; t.cwd = cwd; t.fl = fl;
    t.e_we = e_we; t.e_addr = e_addr; t.e_data = e_data;
    t.e_ff = e_ff; t.e_cnt = e_cnt; t.e_rdy = e_rdy;
    return t;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    in_valid     = t.v;
    in_rd        = t.rd;
    in_result    = t.res;
    in_nan       = t.nan;
    in_overflow  = t.ovf;
    in_underflow = t.unf;
    in_zero      = (t.res[30:0] == 31'd0);
    rf_gnt       = t.gnt;
    csr_we       = t.cwe;
    csr_wdata    = t.cwd;
    flush        = t.fl;
  endtask

  task automatic idle();
    drive(mk(0,0,0, 0,0,0, 0, 0,0, 0, 0,0,0, 0,0,0));
  endtask

  initial begin
    //           v rd  result        nan of uf gnt cwe cwd      fl | we addr data          ff       cnt rdy
    vecs[0]  = mk(1, 3, 32'h4000_0000, 0,0,0, 1, 0,5'b00000, 0,  1, 3, 32'h4000_0000, 5'b00000, 1, 1);
    vecs[1]  = mk(0, 0, 32'h0,         0,0,0, 1, 0,5'b00000, 0,  0, 0, 32'h0,         5'b00000, 0, 1);
    vecs[2]  = mk(1, 1, 32'h3F80_0000, 0,0,0, 0, 0,5'b00000, 0,  1, 1, 32'h3F80_0000, 5'b00000, 1, 1);
    vecs[3]  = mk(1, 2, 32'h4040_0000, 0,0,0, 0, 0,5'b00000, 0,  1, 1, 32'h3F80_0000, 5'b00000, 2, 0);
    vecs[4]  = mk(1, 4, 32'h4080_0000, 0,0,0, 0, 0,5'b00000, 0,  1, 1, 32'h3F80_0000, 5'b00000, 2, 0);
    vecs[5]  = mk(1, 4, 32'h4080_0000, 0,0,0, 1, 0,5'b00000, 0,  1, 2, 32'h4040_0000, 5'b00000, 1, 1);
    vecs[6]  = mk(1, 4, 32'h4080_0000, 0,0,0, 1, 0,5'b00000, 0,  1, 4, 32'h4080_0000, 5'b00000, 1, 1);
    vecs[7]  = mk(0, 0, 32'h0,         0,0,0, 1, 0,5'b00000, 0,  0, 0, 32'h0,         5'b00000, 0, 1);
    vecs[8]  = mk(1, 5, 32'h7F80_0000, 0,1,0, 0, 0,5'b00000, 0,  1, 5, 32'h7F80_0000, 5'b00000, 1, 1);
    vecs[9]  = mk(0, 0, 32'h0,         0,0,0, 1, 0,5'b00000, 0,  0, 0, 32'h0,         5'b00101, 0, 1);
    vecs[10] = mk(0, 0, 32'h0,         0,0,0, 0, 1,5'b00000, 0,  0, 0, 32'h0,         5'b00000, 0, 1);
    vecs[11] = mk(1, 6, 32'hFFC0_0001, 1,0,0, 0, 0,5'b00000, 0,  1, 6, NAN_EXP,       5'b00000, 1, 1);
    vecs[12] = mk(0, 0, 32'h0,         0,0,0, 1, 0,5'b00000, 0,  0, 0, 32'h0,         5'b10000, 0, 1);
    vecs[13] = mk(0, 0, 32'h0,         0,0,0, 0, 1,5'b00000, 0,  0, 0, 32'h0,         5'b00000, 0, 1);
    vecs[14] = mk(1, 7, 32'h0000_0001, 0,0,1, 0, 0,5'b00000, 0,  1, 7, 32'h0000_0001, 5'b00000, 1, 1);
    vecs[15] = mk(1, 8, 32'h3F80_0000, 0,0,0, 0, 0,5'b00000, 0,  1, 7, 32'h0000_0001, 5'b00000, 2, 0);
    vecs[16] = mk(1, 9, 32'h4000_0000, 0,0,0, 1, 0,5'b00000, 1,  0, 0, 32'h0,         5'b00000, 0, 1);
    vecs[17] = mk(0, 0, 32'h0,         0,0,0, 1, 0,5'b00000, 0,  0, 0, 32'h0,         5'b00000, 0, 1);
    vecs[18] = mk(1,10, 32'h7F80_0000, 0,1,0, 0, 0,5'b00000, 0,  1,10, 32'h7F80_0000, 5'b00000, 1, 1);
    vecs[19] = mk(0, 0, 32'h0,         0,0,0, 1, 1,5'b10000, 0,  0, 0, 32'h0,         5'b10101, 0, 1);
    vecs[20] = mk(1,11, 32'h7FC0_0000, 1,0,0, 0, 0,5'b00000, 0,  1,11, 32'h7FC0_0000, 5'b10101, 1, 1);
    vecs[21] = mk(0, 0, 32'h0,         0,0,0, 1, 1,5'b00010, 1,  0, 0, 32'h0,         5'b00010, 0, 1);
    vecs[22] = mk(1,12, 32'h0000_0002, 0,0,1, 1, 0,5'b00000, 0,  1,12, 32'h0000_0002, 5'b00010, 1, 1);
    vecs[23] = mk(0, 0, 32'h0,         0,0,0, 1, 0,5'b00000, 0,  0, 0, 32'h0,         5'b00011, 0, 1);

    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", -1, {31'b0, in_ready}, 32'd0);
    chk("rst_we",    -1, {31'b0, rf_we},    32'd0);
    chk("rst_count", -1, {30'b0, count},    32'd0);
    chk("rst_fflags",-1, {27'b0, fflags},   32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", -1, {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk("rf_we",    i, {31'b0, rf_we},   {31'b0, vecs[i].e_we});
      chk("count",    i, {30'b0, count},   {30'b0, vecs[i].e_cnt});
      chk("fflags",   i, {27'b0, fflags},  {27'b0, vecs[i].e_ff});
      chk("in_ready", i, {31'b0, in_ready},{31'b0, vecs[i].e_rdy});
      if (vecs[i].e_we) begin
        chk("rf_waddr", i, {27'b0, rf_waddr}, {27'b0, vecs[i].e_addr});
        chk("rf_wdata", i, rf_wdata, vecs[i].e_data);
      end
    end

    // Mid-operation reset: two flagged entries queued, reset during a retire.
    drive(mk(1,13, 32'h7F80_0000, 1,1,1, 0, 0,5'b00000, 0, 0,0,0,0,0,0));
    @(posedge clk); #1;
    drive(mk(1,14, 32'h7F80_0000, 1,1,1, 0, 0,5'b00000, 0, 0,0,0,0,0,0));
    @(posedge clk); #1;
    chk("pre_rst_count", 100, {30'b0, count}, 32'd2);
    drive(mk(1,15, 32'h0, 1,1,1, 1, 1,5'b11111, 0, 0,0,0,0,0,0));
    rst_n = 1'b0;
    #1;
    chk("ready_low_in_rst", 100, {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("midrst_count",  100, {30'b0, count},  32'd0);
    chk("midrst_we",     100, {31'b0, rf_we},  32'd0);
    chk("midrst_fflags", 100, {27'b0, fflags}, 32'd0);
    idle();
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_count",  101, {30'b0, count},  32'd0);
    chk("post_rst_fflags", 101, {27'b0, fflags}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
